// File: rtl/mode_sweeper.sv
// mode_sweeper: steps MAIN_MODE/SUB_MODE of the stimulus block through
// MODE_FIRST..MODE_LAST. Each step settles, pulses CLR, dwells, then checks
// the stimulus counters. Pass/fail is sticky and the first failing step is kept.
module mode_sweeper #(
  parameter logic [7:0] MODE_FIRST = 8'd1,
  parameter logic [7:0] MODE_LAST  = 8'd69,
  parameter int         BW_DWELL   = 16,
  parameter int         SETTLE     = 4,
  parameter int         CLR_W      = 2
) (
  input  logic                RSTXF,
  input  logic                CLKF,
  input  logic                START,
  input  logic                ABORT,
  input  logic                SUB_SWEEP,
  input  logic                REQ_RECV,
  input  logic [BW_DWELL-1:0] DWELL,
  input  logic [59:0]         RECV_CNT,
  input  logic [63:0]         ERR_CNT,
  output logic [7:0]          MAIN_MODE,
  output logic [7:0]          SUB_MODE,
  output logic                CLR,
  output logic                BUSY,
  output logic                DONE,
  output logic                FAIL,
  output logic [7:0]          FAIL_MODE,
  output logic                FAIL_SUB
);

  // One counter serves settle, clear and dwell; it must hold SETTLE (<=15).
  localparam int CW = (BW_DWELL > 4) ? BW_DWELL : 4;
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE);
  localparam logic [CW-1:0] CLR_END    = CW'(CLR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_CLEAR, S_DWELL, S_CHECK, S_NEXT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] dwell_end;
  logic [CW-1:0] dwell_in, dwell_end_in;
  logic [7:0]    mode;
  logic          sub;
  logic          sub_sweep_q, req_recv_q;
  logic          last_step, step_fail, go;

  assign go           = START && !ABORT;
  assign dwell_in     = CW'(DWELL);
  // A zero DWELL still dwells one cycle.
  assign dwell_end_in = (dwell_in == '0) ? '0 : dwell_in - CW'(1);
  assign last_step    = !(sub_sweep_q && !sub) && (mode == MODE_LAST);
  assign step_fail    = (ERR_CNT != '0) || (req_recv_q && (RECV_CNT == '0));

  // State, phase counter, and dwell length captured on DWELL entry
  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dwell_end <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_CLEAR && state_nxt == S_DWELL)
        dwell_end <= dwell_end_in;
    end
  end

  // Next-state: each timed phase ends when the counter hits its last cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (go) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        // One entry cycle plus SETTLE held cycles.
        if (cnt == SETTLE_END) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt == CLR_END) begin
          state_nxt = S_DWELL;
          cnt_nxt   = '0;
        end
      end
      S_DWELL: begin
        if (cnt == dwell_end) begin
          state_nxt = S_CHECK;
          cnt_nxt   = '0;
        end
      end
      S_CHECK: begin
        state_nxt = S_NEXT;
        cnt_nxt   = '0;
      end
      S_NEXT: begin
        state_nxt = last_step ? S_IDLE : S_APPLY;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (ABORT && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // Sweep position, sampled options and sticky result flags
  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      mode        <= '0;
      sub         <= 1'b0;
      sub_sweep_q <= 1'b0;
      req_recv_q  <= 1'b0;
      DONE        <= 1'b0;
      FAIL        <= 1'b0;
      FAIL_MODE   <= '0;
      FAIL_SUB    <= 1'b0;
    end else begin
      if (state == S_IDLE && go) begin
        mode        <= MODE_FIRST;
        sub         <= 1'b0;
        sub_sweep_q <= SUB_SWEEP;
        req_recv_q  <= REQ_RECV;
        DONE        <= 1'b0;
        FAIL        <= 1'b0;
        FAIL_MODE   <= '0;
        FAIL_SUB    <= 1'b0;
      end
      if (!ABORT) begin
        if (state == S_CHECK && step_fail && !FAIL) begin
          FAIL      <= 1'b1;
          FAIL_MODE <= mode;
          FAIL_SUB  <= sub;
        end
        if (state == S_NEXT) begin
          // Compare before incrementing so MODE_LAST=255 never wraps.
          if (sub_sweep_q && !sub) begin
            sub <= 1'b1;
          end else if (mode == MODE_LAST) begin
            DONE <= 1'b1;
          end else begin
            mode <= mode + 8'd1;
            sub  <= 1'b0;
          end
        end
      end
    end
  end

  // Registered drive to stimulus; zeroed in the same cycle the FSM reaches IDLE
  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      MAIN_MODE <= '0;
      SUB_MODE  <= '0;
      CLR       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      if (state_nxt == S_IDLE) begin
        MAIN_MODE <= '0;
        SUB_MODE  <= '0;
      end else if (state == S_APPLY) begin
        MAIN_MODE <= mode;
        SUB_MODE  <= {7'b0, sub};
      end
      CLR  <= (state_nxt == S_CLEAR);
      BUSY <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mode_sweeper.sv
// Directed bench for mode_sweeper (MODE_FIRST=1, MODE_LAST=3). Expected CLR
// pulses are queued when a sweep starts and checked as each pulse ends.
module tb_mode_sweeper;

  logic        RSTXF, CLKF, START, ABORT, SUB_SWEEP, REQ_RECV;
  logic [15:0] DWELL;
  logic [59:0] RECV_CNT;
  logic [63:0] ERR_CNT;
  logic [7:0]  MAIN_MODE, SUB_MODE, FAIL_MODE;
  logic        CLR, BUSY, DONE, FAIL, FAIL_SUB;

  mode_sweeper #(
    .MODE_FIRST(8'd1), .MODE_LAST(8'd3), .BW_DWELL(16), .SETTLE(4), .CLR_W(2)
  ) dut (
    .RSTXF(RSTXF), .CLKF(CLKF), .START(START), .ABORT(ABORT),
    .SUB_SWEEP(SUB_SWEEP), .REQ_RECV(REQ_RECV), .DWELL(DWELL),
    .RECV_CNT(RECV_CNT), .ERR_CNT(ERR_CNT), .MAIN_MODE(MAIN_MODE),
    .SUB_MODE(SUB_MODE), .CLR(CLR), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
    .FAIL_MODE(FAIL_MODE), .FAIL_SUB(FAIL_SUB)
  );

  initial CLKF = 1'b0;
  always #5 CLKF = ~CLKF;

  int cyc = 0;
  always @(posedge CLKF) cyc <= cyc + 1;

  // Error injection: ERR_CNT=5 while the chosen mode (and sub, 2=any) is driven.
  logic [7:0] err_mode = 8'hFF;
  logic [1:0] err_sub  = 2'd2;
  assign ERR_CNT = (MAIN_MODE == err_mode &&
                    (err_sub == 2'd2 || {1'b0, SUB_MODE[0]} == err_sub)) ? 64'd5 : 64'd0;

  typedef struct {
    logic [7:0] mode;
    logic [7:0] sub;
    int         width;
    int         period;   // 0: first step of a sweep, no period check
  } step_t;
  step_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one record per CLR pulse, compared against the queue on its falling edge
  int         rise_cyc = 0, prev_rise = 0;
  logic [7:0] rise_mode = '0, rise_sub = '0;
  logic       clr_d = 1'b0;
  always @(negedge CLKF) begin
    if (CLR === 1'b1 && !clr_d) begin
      prev_rise = rise_cyc;
      rise_cyc  = cyc;
      rise_mode = MAIN_MODE;
      rise_sub  = SUB_MODE;
    end
    if (CLR !== 1'b1 && clr_d) begin
      n_cmp++;
      assert (sbq.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_unexpected observed=mode %0d expected=no step", rise_mode);
      end
      if (sbq.size() != 0) begin
        step_t e;
        e = sbq.pop_front();
        chk("step_mode", rise_mode, e.mode);
        chk("step_sub", rise_sub, e.sub);
        chk("clr_width", cyc - rise_cyc, e.width);
        if (e.period != 0) chk("step_period", rise_cyc - prev_rise, e.period);
      end
    end
    clr_d = (CLR === 1'b1);
  end

  task automatic push_sweep(input bit subsw, input int per);
    bit first = 1'b1;
    for (int m = 1; m <= 3; m++)
      for (int s = 0; s <= (subsw ? 1 : 0); s++) begin
        step_t e;
        e.mode   = 8'(m);
        e.sub    = 8'(s);
        e.width  = 2;
        e.period = first ? 0 : per;
        first    = 1'b0;
        sbq.push_back(e);
      end
  endtask

  task automatic push_step(input int m, input int w, input int per);
    step_t e;
    e.mode = 8'(m); e.sub = 8'd0; e.width = w; e.period = per;
    sbq.push_back(e);
  endtask

  task automatic do_start(output int c0);
    @(negedge CLKF);
    START = 1'b1;
    c0    = cyc;
    @(negedge CLKF);
    START = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int exp_len, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (DONE === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge CLKF);
    end
    if (!found) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else        chk(tag, cyc - c0 - 1, exp_len);
  endtask

  task automatic wait_clr(input logic [7:0] m, input logic lvl, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLKF);
      if (CLR === lvl && MAIN_MODE == m) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(tag, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] outs();
    return {MAIN_MODE, SUB_MODE, CLR, BUSY, DONE, FAIL, FAIL_MODE, FAIL_SUB};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    RSTXF = 1'b0; START = 1'b0; ABORT = 1'b0; SUB_SWEEP = 1'b0; REQ_RECV = 1'b0;
    DWELL = 16'd10; RECV_CNT = 60'd100;
    #3 chk("reset_outs", outs(), 64'd0);
    @(negedge CLKF); RSTXF = 1'b1;
    @(negedge CLKF);
    chk("idle_outs", outs(), 64'd0);

    // Plain sweep 1..3, 19-cycle steps
    push_sweep(1'b0, 19);
    do_start(c0);
    wait_done(c0, 57, "sweep_len");
    chk("sweep_flags", {DONE, FAIL, BUSY, MAIN_MODE}, {1'b1, 1'b0, 1'b0, 8'd0});
    chk("sweep_sb_empty", sbq.size(), 0);

    // Sub-mode sweep, SUB_SWEEP only sampled at START
    push_sweep(1'b1, 19);
    SUB_SWEEP = 1'b1;
    do_start(c0);
    SUB_SWEEP = 1'b0;
    wait_done(c0, 114, "sub_len");
    chk("sub_flags", {DONE, FAIL, SUB_MODE}, {1'b1, 1'b0, 8'd0});
    chk("sub_sb_empty", sbq.size(), 0);

    // ERR_CNT during mode 2 only
    err_mode = 8'd2; err_sub = 2'd2;
    push_sweep(1'b0, 19);
    do_start(c0);
    wait_done(c0, 57, "err_len");
    chk("err_flags", {DONE, FAIL, FAIL_MODE, FAIL_SUB}, {1'b1, 1'b1, 8'd2, 1'b0});

    // REQ_RECV with no receives: every step fails, first one is kept
    err_mode = 8'd3; RECV_CNT = 60'd0; REQ_RECV = 1'b1;
    push_sweep(1'b0, 19);
    do_start(c0);
    REQ_RECV = 1'b0;
    wait_done(c0, 57, "recv_len");
    chk("recv_flags", {DONE, FAIL, FAIL_MODE, FAIL_SUB}, {1'b1, 1'b1, 8'd1, 1'b0});
    RECV_CNT = 60'd100;

    // Failure on sub 1 of mode 2; START must clear the old FAIL_MODE
    err_mode = 8'd2; err_sub = 2'd1;
    push_sweep(1'b1, 19);
    SUB_SWEEP = 1'b1;
    do_start(c0);
    SUB_SWEEP = 1'b0;
    wait_done(c0, 114, "subfail_len");
    chk("subfail_flags", {DONE, FAIL, FAIL_MODE, FAIL_SUB}, {1'b1, 1'b1, 8'd2, 1'b1});
    err_mode = 8'hFF; err_sub = 2'd2;

    // DWELL=0 behaves as one cycle: 10-cycle steps
    DWELL = 16'd0;
    push_sweep(1'b0, 10);
    do_start(c0);
    wait_done(c0, 30, "dwell0_len");
    chk("dwell0_flags", {DONE, FAIL}, {1'b1, 1'b0});
    DWELL = 16'd10;

    // START while busy ignored; ABORT in CLEAR of mode 2 keeps FAIL from mode 1
    err_mode = 8'd1;
    push_step(1, 2, 0);
    push_step(2, 1, 19);
    do_start(c0);
    repeat (5) @(negedge CLKF);
    START = 1'b1;
    @(negedge CLKF);
    START = 1'b0;
    wait_clr(8'd2, 1'b1, "abort_wait_clr");
    ABORT = 1'b1;
    @(negedge CLKF);
    ABORT = 1'b0;
    chk("abort_outs", {BUSY, CLR, MAIN_MODE, DONE}, {1'b0, 1'b0, 8'd0, 1'b0});
    chk("abort_fail_kept", {FAIL, FAIL_MODE}, {1'b1, 8'd1});
    @(negedge CLKF);
    chk("abort_sb_empty", sbq.size(), 0);
    err_mode = 8'hFF;

    // START and ABORT together in IDLE: nothing starts, nothing cleared
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLKF);
    START = 1'b0; ABORT = 1'b0;
    @(negedge CLKF);
    chk("start_abort", {BUSY, FAIL, FAIL_MODE, MAIN_MODE}, {1'b0, 1'b1, 8'd1, 8'd0});

    // Asynchronous reset during DWELL of mode 2, then a clean restart
    push_step(1, 2, 0);
    push_step(2, 2, 19);
    do_start(c0);
    wait_clr(8'd2, 1'b1, "rst_wait_clr");
    wait_clr(8'd2, 1'b0, "rst_wait_dwell");
    #2 RSTXF = 1'b0;
    #1 chk("rst_async_outs", outs(), 64'd0);
    @(negedge CLKF);
    RSTXF = 1'b1;
    chk("rst_sb_empty", sbq.size(), 0);
    push_sweep(1'b0, 19);
    do_start(c0);
    wait_done(c0, 57, "restart_len");
    chk("restart_flags", {DONE, FAIL, BUSY}, {1'b1, 1'b0, 1'b0});
    chk("restart_sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
